// File: rtl/global_defs.sv
// Shared MPU definitions: requester count, operand width and the FPU operand/ID types.
package global_defs;
  localparam int FP          = 64;
  localparam int NUM_FPU_REQ = 4;
  localparam int REQ_ID_W    = $clog2(NUM_FPU_REQ);

  typedef logic [REQ_ID_W-1:0] req_id_t;
  typedef struct packed {logic [FP-1:0] a, b;} fpu_operands_t;
endpackage

// File: rtl/req_id_fifo.sv
// In-order tag FIFO of requester IDs with first-word fall-through read.
module req_id_fifo import global_defs::*; #(
  parameter int DEPTH = 8,
  parameter int W     = REQ_ID_W,
  localparam int PW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [PW-1:0] count
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q[PW-2:0]] <= din;
        wr_q <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
    end
  end

  // Equal slot index: the wrap bit tells full (differs) from empty (matches).
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[PW-1] != rd_q[PW-1]) && (wr_q[PW-2:0] == rd_q[PW-2:0]);
  assign count = wr_q - rd_q;
  assign dout  = mem_q[rd_q[PW-2:0]];
endmodule

// File: rtl/fpu_mult_arbiter.sv
// Round-robin sharing of the FPU multiplier between MPU requesters; results are
// routed back through an in-order tag FIFO of winner IDs.
module fpu_mult_arbiter import global_defs::*; #(
  parameter int NUM_REQ   = NUM_FPU_REQ,
  parameter int DATA_W    = FP,
  parameter int TAG_DEPTH = 8,
  localparam int ID_W     = $clog2(NUM_REQ),
  localparam int CNT_W    = $clog2(TAG_DEPTH) + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_a,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           fpu_valid,
  output logic [DATA_W-1:0]              fpu_a,
  output logic [DATA_W-1:0]              fpu_b,
  input  logic                           fpu_ready,
  input  logic                           fpu_res_valid,
  input  logic [DATA_W-1:0]              fpu_res,
  output logic [NUM_REQ-1:0]             res_valid,
  output logic [DATA_W-1:0]              res_data,
  output logic [CNT_W-1:0]               outstanding,
  output logic                           busy,
  output logic                           error
);
  // Returns {found, id}; scanning from lowest priority up lets the nearest-to-ptr hit win.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                            input logic [ID_W-1:0]    p);
    logic [ID_W:0] r;
    int idx;
    r = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      idx = (int'(p) + off) % NUM_REQ;
      if (v[idx]) r = {1'b1, ID_W'(idx)};
    end
    return r;
  endfunction

  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0] res_valid_q, res_valid_d;
  logic [DATA_W-1:0]  res_data_q, res_data_d;
  logic               error_q, error_d;

  logic [ID_W:0]   pick;
  logic            found, can_issue, issue;
  logic [ID_W-1:0] win, fifo_dout;
  logic            fifo_full, fifo_empty, fifo_pop;
  logic [CNT_W-1:0] fifo_count;

  assign pick      = rr_pick(req_valid, ptr_q);
  assign found     = pick[ID_W];
  assign win       = pick[ID_W-1:0];
  assign fifo_pop  = fpu_res_valid && !fifo_empty;
  assign can_issue = fpu_ready && (!fifo_full || fifo_pop) && !rst;
  assign fpu_valid = found && can_issue;
  assign issue     = fpu_valid && fpu_ready;

  always_comb begin
    req_ready = '0;
    fpu_a     = '0;
    fpu_b     = '0;
    if (found) begin
      fpu_a          = req_a[win];
      fpu_b          = req_b[win];
      req_ready[win] = can_issue;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (issue) ptr_d = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    res_valid_d            = '0;
    res_valid_d[fifo_dout] = fifo_pop;
    res_data_d = fifo_pop ? fpu_res : res_data_q;
    // Emptiness is judged before this cycle's push, so a same-cycle issue does not cover a stray result.
    error_d    = error_q | (fpu_res_valid && fifo_empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      res_valid_q <= '0;
      res_data_q  <= '0;
      error_q     <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      error_q     <= error_d;
    end
  end

  req_id_fifo #(.DEPTH(TAG_DEPTH), .W(ID_W)) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (issue),
    .din   (win),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign outstanding = fifo_count;
  assign busy        = |fifo_count;
  assign error       = error_q;
endmodule

// File: doc/fpu_mult_arbiter.md
# fpu_mult_arbiter

Round-robin arbiter that shares the single `fpu_multiplier` between several MPU requesters, such as the row/column dot-product lanes and the load/store scaling path. It accepts operand pairs over per-requester valid/ready handshakes and issues one pair per cycle to the multiplier. It records the winning requester's ID in an in-order tag FIFO, and routes each multiplier result back to the requester that issued it. The block sits between the MPU datapath lanes and the FPU multiplier, inside the MPU.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).
- `DATA_W`, `FP` (64): operand/result width, IEEE-754 double.
- `TAG_DEPTH`, 8: maximum outstanding multiplies; power of two, at least 2.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  `NUM_REQ`  per-requester operand pair valid.
- `req_a`, `req_b`  in  `NUM_REQ`×`DATA_W`  per-requester operands.
- `req_ready`  out  `NUM_REQ`  one-hot-or-zero accept.
- `fpu_valid`  out  1  operand pair to multiplier valid.
- `fpu_a`, `fpu_b`  out  `DATA_W`  operands to multiplier.
- `fpu_ready`  in  1  multiplier can accept.
- `fpu_res_valid`  in  1  multiplier result valid; results are returned in issue order.
- `fpu_res`  in  `DATA_W`  multiplier result.
- `res_valid`  out  `NUM_REQ`  one-hot result strobe, one-cycle pulse.
- `res_data`  out  `DATA_W`  result, shared by all requesters.
- `outstanding`  out  `$clog2(TAG_DEPTH)+1`  issued but not yet returned.
- `busy`  out  1  `outstanding != 0`.
- `error`  out  1  sticky; result arrived with the tag FIFO empty.

## Operation
- **Priority pointer `ptr`:**
  - The requester at `ptr` has highest priority; priority then decreases as (`ptr`+1) mod `NUM_REQ`, (`ptr`+2) mod `NUM_REQ`, and so on.
  - `ptr` resets to 0.
  - On every accepted issue to requester g, `ptr` becomes (g+1) mod `NUM_REQ`. It does not change when nothing is issued.
- **Winner:** the highest-priority requester with `req_valid` set. The winner is combinational.
- **Issue condition:** `can_issue = fpu_ready && (!fifo_full || fifo_pop)`.
- **Outputs while issuing:**
  - `fpu_valid = any(req_valid) && can_issue`.
  - `fpu_a`/`fpu_b` are the winner's operands. When there is no winner they are 0.
  - `req_ready[winner] = can_issue`. All other `req_ready` bits are 0.
- **Issue event** (`fpu_valid && fpu_ready`): push the winner ID into the tag FIFO.
- **Return:**
  - On `fpu_res_valid` with the FIFO non-empty: pop the ID, then on the next cycle drive `res_valid[id] = 1` and `res_data = fpu_res`, both registered.
  - `res_data` holds its value when `res_valid` is 0.
  - Requesters must always accept results; there is no result backpressure.
- **Stray result:** `fpu_res_valid` with the FIFO empty sets `error`. There is no pop and no `res_valid`. `error` clears only on `rst`.
- **Simultaneous issue and return:**
  - Push and pop happen in the same cycle and `outstanding` is unchanged.
  - This is legal even when the FIFO is full.
  - It is legal when the FIFO is empty only if the pop reads the pre-push state. In that case `error` is set, because FIFO-empty is evaluated before the push.
- **`outstanding`:** +1 on issue only, −1 on pop only, unchanged on both.

## Timing
- Request to `fpu_valid`: 0 cycles, combinational through the arbiter.
- `fpu_res_valid` to `res_valid`: 1 cycle.
- Full throughput is one issue per cycle; arbitration introduces no bubbles.
- **Reset values:**
  - `ptr` = 0.
  - FIFO empty.
  - `outstanding` = 0, `busy` = 0, `error` = 0.
  - `res_valid` = 0, `res_data` = 0.
  - `req_ready` and `fpu_valid` are 0 while `rst` is high.
- **Reset mid-operation:**
  - All in-flight tags are discarded.
  - Results returning after `rst` deasserts find the FIFO empty and set `error`. The controller must drain the FPU before asserting `rst`.
- **Requester rules:**
  - A requester holds `req_valid` and its operands stable until `req_ready`.
  - The arbiter may re-arbitrate each cycle.
  - A held request is guaranteed service within `NUM_REQ` issue events.

## Structure
- In `global_defs`:
  - `NUM_FPU_REQ` (4).
  - `REQ_ID_W = $clog2(NUM_FPU_REQ)`.
  - `typedef logic [REQ_ID_W-1:0] req_id_t`.
  - `typedef struct packed {logic [FP-1:0] a, b;} fpu_operands_t`.
- Sub-module `req_id_fifo`: synchronous FIFO of `req_id_t`, depth `TAG_DEPTH`.
  - Pointers are `$clog2(TAG_DEPTH)+1` bits wide; the extra bit is the wrap bit used to tell full from empty.
  - Outputs: `full`, `empty`, `count`.
  - First-word fall-through read.
- The round-robin pick is a function inside `fpu_mult_arbiter`, not a separate module.

## Test plan
- **Single requester:** only requester 2 is valid, with a=2.0 and b=3.0, and the FPU returns 6.0 three cycles later. Required: `req_ready[2]` in the same cycle, then `res_valid = 4'b0100` and `res_data = 6.0` one cycle after `fpu_res_valid`.
- **All requesters saturating:** all four hold `req_valid` for 8 cycles with `fpu_ready = 1`. Required grant order 0,1,2,3,0,1,2,3, with results routed back in that order.
- **Tag FIFO full:** `TAG_DEPTH` = 8 and no results return. Required: 8 issues, then `req_ready` = 0 and `outstanding` = 8. A result arriving while a request is pending causes a pop and a push in the same cycle; `outstanding` stays 8.
- **FPU backpressure:** `fpu_ready` = 0 for 5 cycles while requester 1 is valid. Required: no `req_ready`, `ptr` unchanged, and the grant goes to requester 1 once `fpu_ready` = 1.
- **Stray result:** `fpu_res_valid` with nothing outstanding. Required: `error` = 1 on the next cycle, `res_valid` = 0, and `error` stays set until `rst`.
- **Reset mid-flight:** assert `rst` with 3 results outstanding. Required: `outstanding` = 0, `busy` = 0, `ptr` = 0, and all outputs at their reset values on the cycle after the reset edge.
